nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nsa_pkg.sv | 21 ++
 rtl/nibble_serial_add_ctrl_adder4.sv | 25 ++
 rtl/nibble_serial_add_ctrl.sv | 151 +++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: slice width,
// FSM state encoding and the index-register width helper.
package nsa_pkg;

    // Width of the single adder slice that is reused every cycle.
    localparam int NIBBLE_W = 4;

    // Sequencer states. The encoding is fixed so that debug tooling can decode it.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Width of the nibble index register. It is never narrower than one bit,
    // so that the NIBBLES=1 build still has a legal register.
    function automatic int idx_w(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_adder4.sv
// Purely combinational 4-bit ripple-carry adder slice. The sequencer
// instantiates it exactly once and feeds it one nibble per clock.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    // Ripple the carry through four full-adder bits.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
        cout = carry[4];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built from one reused 4-bit slice, processing one nibble per
// clock, least-significant nibble first.
//
// Handshakes: an operand set transfers on a rising edge where in_valid and
// in_ready are both high; a result transfers on a rising edge where out_valid
// and out_ready are both high. in_ready is high only in IDLE and out_valid is
// high only in DONE, so each side is ignored while the other phase is active.
//
// Optional feature: defining NSA_SUB_EN adds an 'op' input. op=1 computes
// a-b as a + ~b + 1 (cin is ignored and cout=1 means no borrow); op=0 adds.
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NIBBLES*NIBBLE_W-1:0]     a,
    input  logic [NIBBLES*NIBBLE_W-1:0]     b,
    input  logic                            cin,
`ifdef NSA_SUB_EN
    input  logic                            op,
`endif
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NIBBLES*NIBBLE_W-1:0]     sum,
    output logic                            cout,
    output logic [1:0]                      dbg_state
);

    localparam int W     = NIBBLES * NIBBLE_W;
    localparam int IDX_W = idx_w(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e               state_q;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic                 carry_q;
    logic [IDX_W-1:0]     idx_q;
    logic [W-1:0]         sum_q;
    logic                 cout_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
`ifdef NSA_SUB_EN
    logic                 op_q;
`endif

    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  slice_sum;
    logic                 slice_cout;
    logic                 carry_init_d;
    logic [IDX_W-1:0]     idx_d;

    // Select the current operand nibbles; for subtraction B is inverted on its way into the slice.
    always_comb begin
        a_nib = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
`ifdef NSA_SUB_EN
        if (op_q) begin
            b_nib = ~b_nib;
        end
`endif
    end

    // Carry seed at accept time (forced to 1 for subtraction) and the next nibble index.
    always_comb begin
        carry_init_d = cin;
`ifdef NSA_SUB_EN
        if (op) begin
            carry_init_d = 1'b1;
        end
`endif
        idx_d = idx_q + IDX_W'(1);
    end

    adder4 u_adder4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Sequencer FSM together with the operand, result and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef NSA_SUB_EN
            op_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= carry_init_d;
                        idx_q      <= '0;
`ifdef NSA_SUB_EN
                        op_q       <= op;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    // Nibbles above idx keep stale data until they are written.
                    sum_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    idx_q   <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // sum and cout keep their values after the result is taken.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: a 4-nibble instance for the
// handshake, latency, hold and reset scenarios, and a 1-nibble instance
// swept over every a/b/cin combination.
module tb_nibble_serial_add_ctrl;
    import nsa_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   dbg_state;

    logic         in_valid1;
    logic         in_ready1;
    logic [3:0]   a1;
    logic [3:0]   b1;
    logic         cin1;
    logic         out_valid1;
    logic         out_ready1;
    logic [3:0]   sum1;
    logic         cout1;
    logic [1:0]   dbg_state1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(N)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NSA_SUB_EN
        .op        (op_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .dbg_state (dbg_state)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
`ifdef NSA_SUB_EN
        .op        (1'b0),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .dbg_state (dbg_state1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation with out_ready held high; checks latency and result.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic top,
                          input logic [W-1:0] es, input logic ec);
        int cycles;
        check({tag, "/in_ready_pre"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_v; cin = tc; op_s = top;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        a    = 16'($urandom_range(0, 65535));
        b    = 16'($urandom_range(0, 65535));
        cin  = 1'($urandom_range(0, 1));
        op_s = 1'($urandom_range(0, 1));
        check({tag, "/state_run"}, 32'(dbg_state), 32'(RUN));
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 32) begin
            tick();
            cycles++;
        end
        check({tag, "/latency"}, 32'(cycles), 32'(N));
        check({tag, "/sum"}, 32'(sum), 32'(es));
        check({tag, "/cout"}, 32'(cout), 32'(ec));
        check({tag, "/in_ready_done"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "/idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "/idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "/sum_kept"}, 32'(sum), 32'(es));
    endtask

    initial begin
        int cycles;
        logic [4:0] exp5;

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_s = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;

        // Reset held for three cycles.
        tick(); tick(); tick();
        check("rst/in_ready", 32'(in_ready), 32'd1);
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/sum", 32'(sum), 32'h0000);
        check("rst/cout", 32'(cout), 32'd0);
        check("rst/state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;

        // Accepted in the first cycle after release.
        run_op("add_1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
        run_op("ripple_ffff", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        run_op("top_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_op("mixed", 16'h0F0F, 16'h0101, 1'b1, 1'b0, 16'h1011, 1'b0);

        // Hold the result in DONE with out_ready low while new operands are offered.
        a = 16'h0F0F; b = 16'h0101; cin = 1'b1; op_s = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 32) begin
            tick();
            cycles++;
        end
        check("hold/latency", 32'(cycles), 32'(N));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold/out_valid", 32'(out_valid), 32'd1);
            check("hold/in_ready", 32'(in_ready), 32'd0);
            check("hold/sum", 32'(sum), 32'h1011);
            check("hold/cout", 32'(cout), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("hold/release_idle", 32'(dbg_state), 32'(IDLE));
        check("hold/release_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("hold/next_accept", 32'(dbg_state), 32'(RUN));
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 32) begin
            tick();
            cycles++;
        end
        check("next/latency", 32'(cycles), 32'(N));
        check("next/sum", 32'(sum), 32'hFFFE);
        check("next/cout", 32'(cout), 32'd1);
        tick();

        // Reset two cycles into RUN aborts the operation.
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("abort/state", 32'(dbg_state), 32'(IDLE));
        check("abort/in_ready", 32'(in_ready), 32'd1);
        check("abort/out_valid", 32'(out_valid), 32'd0);
        check("abort/sum", 32'(sum), 32'h0000);
        check("abort/cout", 32'(cout), 32'd0);
        tick();
        rst_n = 1'b1;
        run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

`ifdef NSA_SUB_EN
        run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        run_op("op0_add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
`endif

        // Single-nibble instance over every a/b/cin combination.
        out_ready1 = 1'b1;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a1 = 4'(ia); b1 = 4'(ib); cin1 = 1'(ic);
                    in_valid1 = 1'b1;
                    tick();
                    in_valid1 = 1'b0;
                    a1 = 4'($urandom_range(0, 15));
                    tick();
                    exp5 = 5'(ia + ib + ic);
                    check("n1/out_valid", 32'(out_valid1), 32'd1);
                    check("n1/sum", 32'(sum1), 32'(exp5[3:0]));
                    check("n1/cout", 32'(cout1), 32'(exp5[4]));
                    tick();
                end
            end
        end
        check("n1/final_ready", 32'(in_ready1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
